// File: rtl/flag_rename_pkg.sv
// Shared sizes and the entry-name type for the flag rename free-list.
package flag_rename_pkg;

    localparam int unsigned FLAG_ENTRY_NUM = 16;
    localparam int unsigned FLAG_REGNAME_W = 4;

    typedef logic [FLAG_REGNAME_W-1:0] regname_t;

endpackage

// File: rtl/flag_freelist_prienc.sv
// Finds the two lowest set bits of the free bitmap and counts all set bits.
module flag_freelist_prienc
    import flag_rename_pkg::*;
(
    input  logic [FLAG_ENTRY_NUM-1:0] bits,
    output logic                      first_valid,
    output regname_t                  first_idx,
    output logic                      second_valid,
    output regname_t                  second_idx,
    output logic [4:0]                count
);

    always_comb begin
        first_valid  = 1'b0;
        first_idx    = '0;
        second_valid = 1'b0;
        second_idx   = '0;
        count        = '0;
        for (int unsigned i = 0; i < FLAG_ENTRY_NUM; i++) begin
            if (bits[i]) begin
                if (!first_valid) begin
                    first_valid = 1'b1;
                    first_idx   = regname_t'(i);
                end else if (!second_valid) begin
                    second_valid = 1'b1;
                    second_idx   = regname_t'(i);
                end
                count = count + 5'd1;
            end
        end
    end

endmodule

// File: rtl/flag_rename_freelist.sv
// Free-list for the flag rename entries: acknowledges free requests and
// hands out up to two entry names per cycle to rename/dispatch.
module flag_rename_freelist
    import flag_rename_pkg::*;
#(
    parameter int ENTRIES = FLAG_ENTRY_NUM
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iREMOVE_VALID,
    input  logic [ENTRIES-1:0] iENTRY_FREELIST_REQ,
    output logic [ENTRIES-1:0] oENTRY_FREELIST_REGIST_VALID,
    input  logic               iALLOC_0_REQ,
    input  logic               iALLOC_1_REQ,
    output logic               oALLOC_0_VALID,
    output regname_t           oALLOC_0_REGNAME,
    output logic               oALLOC_1_VALID,
    output regname_t           oALLOC_1_REGNAME,
    output logic [4:0]         oFREE_COUNT,
    output logic               oEMPTY
);

    logic [ENTRIES-1:0] b_free;
    logic [ENTRIES-1:0] b_ack;
    logic [ENTRIES-1:0] accept;
    logic [ENTRIES-1:0] granted;
    logic               pick0_valid;
    logic               pick1_valid;
    regname_t           pick0;
    regname_t           pick1;
    logic [4:0]         free_count;
    logic               grant0;
    logic               grant1;

    flag_freelist_prienc u_prienc (
        .bits         (b_free),
        .first_valid  (pick0_valid),
        .first_idx    (pick0),
        .second_valid (pick1_valid),
        .second_idx   (pick1),
        .count        (free_count)
    );

    // b_ack guard stops a still-high request from being acked twice
    assign accept = iENTRY_FREELIST_REQ & ~b_free & ~b_ack & {ENTRIES{~iREMOVE_VALID}};

    assign grant0 = iALLOC_0_REQ & pick0_valid & ~iREMOVE_VALID;
    assign grant1 = iALLOC_0_REQ & iALLOC_1_REQ & pick1_valid & ~iREMOVE_VALID;

    always_comb begin
        granted = '0;
        if (grant0) granted[pick0] = 1'b1;
        if (grant1) granted[pick1] = 1'b1;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            b_free <= '0;
            b_ack  <= '0;
        end else if (iREMOVE_VALID) begin
            b_free <= '0;
            b_ack  <= '0;
        end else begin
            b_ack  <= accept;
            b_free <= (b_free & ~granted) | b_ack;
        end
    end

    assign oENTRY_FREELIST_REGIST_VALID = b_ack;
    assign oALLOC_0_VALID   = grant0;
    assign oALLOC_0_REGNAME = grant0 ? pick0 : '0;
    assign oALLOC_1_VALID   = grant1;
    assign oALLOC_1_REGNAME = grant1 ? pick1 : '0;
    assign oFREE_COUNT      = free_count;
    assign oEMPTY           = (free_count == 5'd0);

endmodule

// File: doc/flag_rename_freelist.md
# flag_rename_freelist

Free-list allocator for the 16 flag rename entries. Each entry raises a free request when it becomes free. This block acknowledges that request, records the entry as allocatable, and hands up to two entry names per cycle to the rename/dispatch stage. The dispatch stage then drives the entries' register ports with those names. The block sits in scheduling2, alongside the per-entry flag rename management instances.

## Interface
Parameters:
- ENTRIES, 16: number of flag rename entries. Fixed at 16 because entry names are 4 bits.

Ports (signal, direction, width, meaning):
- iCLOCK, in, 1: clock.
- inRESET, in, 1: reset, asynchronous, active-low.
- iREMOVE_VALID, in, 1: pipeline flush.
- iENTRY_FREELIST_REQ, in, 16: per-entry free request. Entry i stays high until it is acknowledged.
- oENTRY_FREELIST_REGIST_VALID, out, 16: per-entry acknowledge, a one-cycle pulse. Wires to each entry's free-list-registered input.
- iALLOC_0_REQ, in, 1: rename slot 0 needs a flag register.
- iALLOC_1_REQ, in, 1: rename slot 1 needs a flag register. Honoured only when iALLOC_0_REQ is also high.
- oALLOC_0_VALID, out, 1: slot 0 grant.
- oALLOC_0_REGNAME, out, 4: slot 0 entry name.
- oALLOC_1_VALID, out, 1: slot 1 grant.
- oALLOC_1_REGNAME, out, 4: slot 1 entry name.
- oFREE_COUNT, out, 5: popcount of the free bitmap, 0 to 16.
- oEMPTY, out, 1: high when oFREE_COUNT == 0.

## Operation
State:
- b_free[15:0]: free bitmap, one bit per allocatable entry.
- b_ack[15:0]: registered acknowledge; it directly drives oENTRY_FREELIST_REGIST_VALID.

Accept rule:
- Entry i is accepted in a cycle when iENTRY_FREELIST_REQ[i] & ~b_free[i] & ~b_ack[i] & ~iREMOVE_VALID.
- Acceptance sets b_ack[i] at the next edge.
- b_ack clears after one cycle, so every acknowledge is a single-cycle pulse.
- Any number of entries, up to all 16, may be accepted in the same cycle.

Bitmap insert:
- At each edge, b_free[i] is set from b_ack[i]. An entry becomes allocatable only once the entry itself has seen the acknowledge and moved to its register-wait state.

Allocation (combinational from b_free):
- L0 is the lowest set bit of b_free; L1 is the second-lowest set bit.
- oALLOC_0_VALID = iALLOC_0_REQ & (count ≥ 1) & ~iREMOVE_VALID, with REGNAME = L0.
- oALLOC_1_VALID = iALLOC_0_REQ & iALLOC_1_REQ & (count ≥ 2) & ~iREMOVE_VALID, with REGNAME = L1.
- If only one entry is free and both slots request, only slot 0 is granted.
- A REGNAME output reads 4'h0 whenever its VALID is low.
- Granted bits clear at the edge.

Bitmap update at each edge: b_free = (b_free & ~granted) | b_ack. An insert and a grant on the same bit cannot coincide, because b_ack[i] implies b_free[i] = 0.

Flush:
- iREMOVE_VALID clears b_free and b_ack at the next edge.
- It suppresses all grants and accepts in that cycle.
- Flushed entries in register-wait reset and re-request, so no name is duplicated.
- Entries in commit-wait ignore the flush and re-request later through the normal path.

## Timing
- Reset: b_free = 0, b_ack = 0. Every output is 0 except oEMPTY = 1.
- Request high in cycle t: ack high in cycle t+1 only; the bit is allocatable from cycle t+2.
- Entry request drops in t+2. In t+1 the b_ack guard blocks a second accept.
- Grant is same-cycle combinational. The bit is absent from cycle t+1 onward.
- oFREE_COUNT and oEMPTY are combinational from b_free.
- A mid-operation reset (inRESET low) clears all state immediately, without waiting for a clock edge.

## Structure
- Package flag_rename_pkg holds:
  - FLAG_ENTRY_NUM = 16
  - FLAG_REGNAME_W = 4
  - a regname typedef
- Sub-module flag_freelist_prienc: a 16-bit input producing the two lowest set-bit indices, each with its own valid, plus the popcount. It is purely combinational.

## Test plan
- Reset, then raise iENTRY_FREELIST_REQ = 16'h0005 and hold it until acked:
  - ack = 16'h0005 for exactly one cycle
  - oFREE_COUNT = 2 two cycles after the request
  - no second ack
- Free = {3, 7, 9}, both slots request: grants 3 and 7. Next cycle the same request gets slot 0 = 9 and oALLOC_1_VALID = 0.
- iALLOC_1_REQ alone with 5 entries free: both grants low and b_free unchanged.
- All 16 entries request in the same cycle: a single ack = 16'hFFFF. Two cycles later oFREE_COUNT = 16 and oEMPTY = 0.
- iREMOVE_VALID in the cycle of a pending grant and ack:
  - grants low, no ack
  - next cycle oFREE_COUNT = 0
  - entries re-request and are acked afresh
- Steady state: 1000 random cycles of request/alloc/remove. The scoreboard checks:
  - no name is granted twice without an intervening ack
  - count equals the model count.
